// File: rtl/cook_timer_pkg.sv
// cook_timer_pkg: shared state encodings and BCD limits for the cook timer
package cook_timer_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALARM = 2'd3
  } state_e;
  localparam logic [3:0] SEC10_MAX = 4'd5;
  localparam logic [3:0] DIGIT_MAX = 4'd9;
endpackage

// File: rtl/bcd_mmss_counter.sv
// bcd_mmss_counter: MM:SS BCD register with wrapping set increments and borrow-chain decrement
module bcd_mmss_counter
  import cook_timer_pkg::*;
#(
  parameter int MAX_MIN10 = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       inc_sec,
  input  logic       inc_min,
  input  logic       dec,
  output logic [3:0] min10,
  output logic [3:0] min1,
  output logic [3:0] sec10,
  output logic [3:0] sec1,
  output logic       is_zero
);
  localparam logic [3:0] MIN10_MAX = 4'(MAX_MIN10);
  logic [3:0] min10_q, min1_q, sec10_q, sec1_q;
  logic [3:0] min10_d, min1_d, sec10_d, sec1_d;
  logic       z_s1, z_s10, z_m1, z_m10;
  assign z_s1    = sec1_q == 4'd0;
  assign z_s10   = sec10_q == 4'd0;
  assign z_m1    = min1_q == 4'd0;
  assign z_m10   = min10_q == 4'd0;
  assign is_zero = z_s1 && z_s10 && z_m1 && z_m10;
  assign min10   = min10_q;
  assign min1    = min1_q;
  assign sec10   = sec10_q;
  assign sec1    = sec1_q;
  always_comb begin
    min10_d = min10_q;
    min1_d  = min1_q;
    sec10_d = sec10_q;
    sec1_d  = sec1_q;
    if (clear) begin
      min10_d = 4'd0;
      min1_d  = 4'd0;
      sec10_d = 4'd0;
      sec1_d  = 4'd0;
    end else if (dec && !is_zero) begin
      sec1_d  = z_s1 ? DIGIT_MAX : sec1_q - 4'd1;
      sec10_d = z_s1 ? (z_s10 ? SEC10_MAX : sec10_q - 4'd1) : sec10_q;
      min1_d  = (z_s1 && z_s10) ? (z_m1 ? DIGIT_MAX : min1_q - 4'd1) : min1_q;
      min10_d = (z_s1 && z_s10 && z_m1) ? min10_q - 4'd1 : min10_q;
    end else begin
      // seconds and minutes wrap independently while setting
      if (inc_sec) begin
        sec1_d  = sec1_q == DIGIT_MAX ? 4'd0 : sec1_q + 4'd1;
        sec10_d = sec1_q != DIGIT_MAX ? sec10_q : sec10_q == SEC10_MAX ? 4'd0 : sec10_q + 4'd1;
      end
      if (inc_min) begin
        min1_d  = min1_q == DIGIT_MAX ? 4'd0 : min1_q + 4'd1;
        min10_d = min1_q != DIGIT_MAX ? min10_q : min10_q == MIN10_MAX ? 4'd0 : min10_q + 4'd1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      min10_q <= 4'd0;
      min1_q  <= 4'd0;
      sec10_q <= 4'd0;
      sec1_q  <= 4'd0;
    end else begin
      min10_q <= min10_d;
      min1_q  <= min1_d;
      sec10_q <= sec10_d;
      sec1_q  <= sec1_d;
    end
  end
endmodule

// File: rtl/cook_timer_ctrl.sv
// cook_timer_ctrl: countdown timer FSM with bounded alarm, driving BCD digits for the display scanner
module cook_timer_ctrl
  import cook_timer_pkg::*;
#(
  parameter int ALARM_TICKS = 10,
  parameter int MAX_MIN10   = 9
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               tick_sec,
  input  logic               btn_start,
  input  logic               btn_clear,
  input  logic               btn_inc_sec,
  input  logic               btn_inc_min,
  output logic [3:0]         min10,
  output logic [3:0]         min1,
  output logic [3:0]         sec10,
  output logic [3:0]         sec1,
  output logic               running,
  output logic               alarm,
  output logic [STATE_W-1:0] state
);
  state_e     state_q, state_d;
  logic [7:0] acnt_q, acnt_d;
  logic       running_q, running_d, alarm_q, alarm_d;
  logic       is_zero, last_sec, any_btn, set_ok;
  assign any_btn  = btn_start || btn_clear || btn_inc_sec || btn_inc_min;
  assign last_sec = {min10, min1, sec10, sec1} == 16'h0001;
  // start outranks the inc buttons, so setting only happens on a start-free cycle
  assign set_ok   = state_q == ST_IDLE && !btn_start && !btn_clear;
  bcd_mmss_counter #(.MAX_MIN10(MAX_MIN10)) u_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (btn_clear),
    .inc_sec (set_ok && btn_inc_sec),
    .inc_min (set_ok && btn_inc_min),
    .dec     (state_q == ST_RUN && tick_sec),
    .min10   (min10),
    .min1    (min1),
    .sec10   (sec10),
    .sec1    (sec1),
    .is_zero (is_zero)
  );
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      acnt_q    <= 8'd0;
      running_q <= 1'b0;
      alarm_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acnt_q    <= acnt_d;
      running_q <= running_d;
      alarm_q   <= alarm_d;
    end
  end
  always_comb begin
    state_d = state_q;
    if (btn_clear) state_d = ST_IDLE;
    else begin
      case (state_q)
        ST_IDLE:  state_d = (btn_start && !is_zero) ? ST_RUN : ST_IDLE;
        ST_RUN:   state_d = (tick_sec && last_sec) ? ST_ALARM : btn_start ? ST_PAUSE : ST_RUN;
        ST_PAUSE: state_d = btn_start ? ST_RUN : ST_PAUSE;
        default:  state_d = (any_btn || (tick_sec && acnt_q == 8'(ALARM_TICKS - 1))) ? ST_IDLE : ST_ALARM;
      endcase
    end
    acnt_d = (state_q == ST_ALARM && state_d == ST_ALARM) ? acnt_q + 8'(tick_sec) : 8'd0;
  end
  always_comb begin
    running_d = state_d == ST_RUN;
    alarm_d   = state_d == ST_ALARM;
  end
  assign running = running_q;
  assign alarm   = alarm_q;
  assign state   = state_q;
endmodule

// File: tb/tb_cook_timer_ctrl.sv
// tb_cook_timer_ctrl: directed plus random stimulus checked against a seconds-count reference model
module tb_cook_timer_ctrl;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick_sec = 1'b0, btn_start = 1'b0, btn_clear = 1'b0, btn_inc_sec = 1'b0, btn_inc_min = 1'b0;
  logic [3:0] min10, min1, sec10, sec1;
  logic       running, alarm;
  logic [1:0] state;
  int         passed = 0, total = 0;
  int         mv = 0, mst = 0, mac = 0;
  localparam int ATICKS = 10;
  localparam int MMOD   = 100;

  cook_timer_ctrl #(.ALARM_TICKS(ATICKS), .MAX_MIN10(9)) dut (
    .clk(clk), .reset_n(reset_n), .tick_sec(tick_sec), .btn_start(btn_start),
    .btn_clear(btn_clear), .btn_inc_sec(btn_inc_sec), .btn_inc_min(btn_inc_min),
    .min10(min10), .min1(min1), .sec10(sec10), .sec1(sec1),
    .running(running), .alarm(alarm), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [15:0] digs();
    return {min10, min1, sec10, sec1};
  endfunction

  task automatic check_all();
    chk("min10", 32'(min10), 32'((mv / 60) / 10));
    chk("min1", 32'(min1), 32'((mv / 60) % 10));
    chk("sec10", 32'(sec10), 32'((mv % 60) / 10));
    chk("sec1", 32'(sec1), 32'((mv % 60) % 10));
    chk("state", 32'(state), 32'(mst));
    chk("running", 32'(running), 32'(mst == 1));
    chk("alarm", 32'(alarm), 32'(mst == 3));
  endtask

  // states: 0 idle, 1 run, 2 pause, 3 alarm; mv is the value in whole seconds
  task automatic model(input bit t, input bit s, input bit c, input bit is, input bit im);
    case (mst)
      0: if (c) mv = 0;
         else if (s) begin if (mv != 0) mst = 1; end
         else begin
           if (is) mv = (mv / 60) * 60 + ((mv % 60) + 1) % 60;
           if (im) mv = (((mv / 60) + 1) % MMOD) * 60 + mv % 60;
         end
      1: if (c) begin mst = 0; mv = 0; end
         else begin
           if (t) mv = mv - 1;
           if (t && mv == 0) mst = 3; else if (s) mst = 2;
         end
      2: if (c) begin mst = 0; mv = 0; end
         else if (s) mst = 1;
      default: if (c || s || is || im) begin mst = 0; mac = 0; end
               else if (t) begin
                 mac++;
                 if (mac == ATICKS) begin mst = 0; mac = 0; end
               end
    endcase
  endtask

  task automatic step(input bit t, input bit s, input bit c, input bit is, input bit im);
    tick_sec = t; btn_start = s; btn_clear = c; btn_inc_sec = is; btn_inc_min = im;
    @(posedge clk);
    model(t, s, c, is, im);
    @(negedge clk);
    tick_sec = 0; btn_start = 0; btn_clear = 0; btn_inc_sec = 0; btn_inc_min = 0;
    check_all();
  endtask

  task automatic set_val(input int m, input int s);
    step(0, 0, 1, 0, 0);
    repeat (m) step(0, 0, 0, 0, 1);
    repeat (s) step(0, 0, 0, 1, 0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check_all();
    reset_n = 1'b1;
    step(0, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0);
    step(0, 0, 0, 0, 1);
    chk("set_0103", 32'(digs()), 32'h0103);
    repeat (57) step(0, 0, 0, 1, 0);
    chk("sec_wrap", 32'(digs()), 32'h0100);
    step(0, 0, 0, 1, 1);
    chk("inc_both", 32'(digs()), 32'h0201);

    set_val(0, 2);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("cnt_0001", 32'(digs()), 32'h0001);
    step(1, 0, 0, 0, 0);
    chk("alarm_on", 32'({alarm, running, state}), 32'b10_11);
    repeat (ATICKS - 1) step(1, 0, 0, 0, 0);
    chk("alarm_hold", 32'(state), 32'd3);
    step(1, 0, 0, 0, 0);
    chk("alarm_end", 32'({alarm, state}), 32'b0_00);

    set_val(1, 0);
    step(1, 1, 0, 0, 0);
    chk("start_no_dec", 32'({digs(), 2'(state)}), {16'h0100, 2'd1});
    step(1, 0, 0, 0, 0);
    chk("dec_borrow", 32'(digs()), 32'h0059);
    step(0, 1, 0, 0, 0);
    repeat (3) step(1, 0, 0, 1, 1);
    chk("pause_frozen", 32'({digs(), 2'(state)}), {16'h0059, 2'd2});
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    chk("resume_dec", 32'(digs()), 32'h0058);

    step(0, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0);
    chk("start_zero", 32'({running, state}), 32'b0_00);
    set_val(0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    chk("alarm_btn_exit", 32'({digs(), 2'(state)}), {16'h0000, 2'd0});

    set_val(0, 1);
    step(0, 1, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("tick_start_zero", 32'(state), 32'd3);
    set_val(5, 0);
    step(0, 1, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    chk("tick_clear", 32'({digs(), 2'(state)}), {16'h0000, 2'd0});

    set_val(12, 34);
    step(0, 1, 0, 0, 0);
    #2 reset_n = 1'b0;
    #1 mv = 0; mst = 0; mac = 0;
    check_all();
    chk("async_rst", 32'({digs(), running}), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) step(1, 0, 0, 0, 0);
    chk("post_rst", 32'({digs(), 2'(state)}), 32'h0);

    for (int i = 0; i < 4000; i++)
      step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 6, $urandom_range(0, 99) < 1,
           $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
